// File: rtl/fifo1c_gen_if.sv
// fifo1c_gen_if: write/read/threshold/status bundle for fifo1c_gen
interface fifo1c_gen_if #(
  parameter int DATA_WIDTH = 108,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic wrreq;
  logic rdreq;
  logic [ADDR_WIDTH:0] aful_thres;
  logic [ADDR_WIDTH:0] aemp_thres;
  logic highest_clr;
  logic [DATA_WIDTH-1:0] q;
  logic empty;
  logic full;
  logic almost_empty;
  logic almost_full;
  logic [ADDR_WIDTH:0] usedw;
  logic [ADDR_WIDTH:0] highest_dw;
  logic overflow;
  logic underflow;
  logic [CNT_WIDTH-1:0] ovf_cnt;
  modport master (
    output data, wrreq, rdreq, aful_thres, aemp_thres, highest_clr,
    input q, empty, full, almost_empty, almost_full, usedw, highest_dw, overflow, underflow, ovf_cnt
  );
  modport slave (
    input data, wrreq, rdreq, aful_thres, aemp_thres, highest_clr,
    output q, empty, full, almost_empty, almost_full, usedw, highest_dw, overflow, underflow, ovf_cnt
  );
endinterface

// File: rtl/fifo1c_gen.sv
// fifo1c_gen: parametrised single-clock FIFO with show-ahead option, run-time thresholds and drop statistics
module fifo1c_gen #(
  parameter int DATA_WIDTH = 108,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SHOWAHEAD = 0,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  fifo1c_gen_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] usedw_q, usedw_d, highest_q, highest_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic empty_q, full_q, aemp_q, aful_q, ovf_q, udf_q;
  logic wr_acc, rd_acc, drop, ign;
  // accept/reject decisions and next-state values, all from registered status
  always_comb begin
    wr_acc = bus.wrreq & ~full_q;
    rd_acc = bus.rdreq & ~empty_q;
    drop = bus.wrreq & full_q;
    ign = bus.rdreq & empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    usedw_d = usedw_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    highest_d = bus.highest_clr ? usedw_d : (usedw_d > highest_q ? usedw_d : highest_q);
    ovf_cnt_d = bus.highest_clr ? '0 : (drop && !(&ovf_cnt_q)) ? ovf_cnt_q + CNT_WIDTH'(1) : ovf_cnt_q;
    q_d = rd_acc ? mem[rd_ptr_q] : q_q;
  end
  // storage array; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= bus.data;
  end
  // pointers, occupancy, registered status flags and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q <= '0;
      highest_q <= '0;
      ovf_cnt_q <= '0;
      q_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      aemp_q <= 1'b1;
      aful_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q <= usedw_d;
      highest_q <= highest_d;
      ovf_cnt_q <= ovf_cnt_d;
      q_q <= q_d;
      empty_q <= usedw_d == '0;
      full_q <= usedw_d == FULL_LVL;
      aemp_q <= usedw_d <= bus.aemp_thres;
      aful_q <= usedw_d >= bus.aful_thres;
      ovf_q <= drop;
      udf_q <= ign;
    end
  end
  assign bus.q = (SHOWAHEAD != 0) ? mem[rd_ptr_q] : q_q;
  assign bus.empty = empty_q;
  assign bus.full = full_q;
  assign bus.almost_empty = aemp_q;
  assign bus.almost_full = aful_q;
  assign bus.usedw = usedw_q;
  assign bus.highest_dw = highest_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.ovf_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_fifo1c_gen.sv
// tb_fifo1c_gen: queue-model checker for a normal-mode (2-bit counter) and a show-ahead FIFO driven in parallel
module tb_fifo1c_gen;
  localparam int DW = 108;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] data = '0;
  logic wrreq = 1'b0;
  logic rdreq = 1'b0;
  logic [AW:0] aful_thres = 5'd12;
  logic [AW:0] aemp_thres = 5'd3;
  logic highest_clr = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  fifo1c_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) b0 ();
  fifo1c_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) b1 ();
  assign b0.data = data;
  assign b0.wrreq = wrreq;
  assign b0.rdreq = rdreq;
  assign b0.aful_thres = aful_thres;
  assign b0.aemp_thres = aemp_thres;
  assign b0.highest_clr = highest_clr;
  assign b1.data = data;
  assign b1.wrreq = wrreq;
  assign b1.rdreq = rdreq;
  assign b1.aful_thres = aful_thres;
  assign b1.aemp_thres = aemp_thres;
  assign b1.highest_clr = highest_clr;
  fifo1c_gen #(.DATA_WIDTH(DW), .DEPTH(16), .SHOWAHEAD(0), .CNT_WIDTH(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  fifo1c_gen #(.DATA_WIDTH(DW), .DEPTH(16), .SHOWAHEAD(1), .CNT_WIDTH(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q;
  int m_hi, m_ovf;
  bit m_of, m_uf, m_ae, m_af, started;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // reference model: a word queue plus plain counters, updated on each edge
  always @(posedge clk) begin
    bit wa, ra;
    if (rst) begin
      mq.delete();
      m_q = '0; m_hi = 0; m_ovf = 0; m_of = 0; m_uf = 0; m_ae = 1; m_af = 0;
      started = 1;
    end else begin
      wa = wrreq && mq.size() < 16;
      ra = rdreq && mq.size() > 0;
      m_of = wrreq && mq.size() == 16;
      m_uf = rdreq && mq.size() == 0;
      if (ra) m_q = mq.pop_front();
      if (wa) mq.push_back(data);
      if (highest_clr) begin
        m_hi = mq.size();
        m_ovf = 0;
      end else begin
        if (mq.size() > m_hi) m_hi = mq.size();
        if (m_of) m_ovf++;
      end
      m_ae = mq.size() <= int'(aemp_thres);
      m_af = mq.size() >= int'(aful_thres);
    end
  end
  // every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("usedw", b0.usedw, mq.size());
      chk("usedw_sa", b1.usedw, mq.size());
      chk("empty", b0.empty, mq.size() == 0);
      chk("full", b0.full, mq.size() == 16);
      chk("aempty", b0.almost_empty, m_ae);
      chk("afull", b0.almost_full, m_af);
      chk("highest", b0.highest_dw, m_hi);
      chk("overflow", b0.overflow, m_of);
      chk("underflow", b0.underflow, m_uf);
      chk("empty_sa", b1.empty, mq.size() == 0);
      chk("overflow_sa", b1.overflow, m_of);
      chk("ovf_cnt2", b0.ovf_cnt, m_ovf > 3 ? 3 : m_ovf);
      chk("ovf_cnt16", b1.ovf_cnt, m_ovf > 65535 ? 65535 : m_ovf);
      chk("q", b0.q, m_q);
      if (mq.size() > 0) chk("q_sa", b1.q, mq[0]);
    end
  end
  initial begin
    step(2);
    rst = 0;
    chk("rst_usedw", b0.usedw, 0);
    chk("rst_empty", b0.empty, 1);
    chk("rst_q", b0.q, 0);
    chk("rst_aempty", b0.almost_empty, 1);
    wrreq = 1;
    for (int i = 0; i < 16; i++) begin
      data = DW'(i);
      step();
      if (i == 11) chk("afull_at12", b0.almost_full, 1);
      if (i == 10) chk("afull_at11", b0.almost_full, 0);
    end
    chk("fill_full", b0.full, 1);
    chk("fill_usedw", b0.usedw, 16);
    chk("fill_highest", b0.highest_dw, 16);
    data = 99;
    step();
    chk("ovf_pulse", b0.overflow, 1);
    step(2);
    chk("ovf_cnt3", b0.ovf_cnt, 3);
    rdreq = 1;
    step();
    chk("drop_rd_usedw", b0.usedw, 15);
    chk("drop_rd_q", b0.q, 0);
    chk("ovf_cnt_sat", b0.ovf_cnt, 3);
    chk("ovf_cnt4", b1.ovf_cnt, 4);
    wrreq = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("rd_seq", b0.q, i);
    end
    chk("drain_empty", b0.empty, 1);
    step();
    chk("udf_pulse", b0.underflow, 1);
    chk("udf_hold_q", b0.q, 15);
    rdreq = 0;
    wrreq = 1;
    for (int i = 0; i < 12; i++) begin
      data = DW'(32 + i);
      step();
    end
    wrreq = 0;
    rdreq = 1;
    for (int i = 0; i < 9; i++) step();
    chk("aempty_at3", b0.almost_empty, 1);
    rdreq = 0;
    wrreq = 1;
    data = 77;
    step(2);
    wrreq = 0;
    chk("usedw5", b0.usedw, 5);
    highest_clr = 1;
    step();
    highest_clr = 0;
    chk("clr_highest", b0.highest_dw, 5);
    chk("clr_ovf", b1.ovf_cnt, 0);
    wrreq = 1;
    data = 88;
    step(11);
    step(5);
    chk("drop5_cnt2", b0.ovf_cnt, 3);
    chk("drop5_cnt16", b1.ovf_cnt, 5);
    highest_clr = 1;
    step();
    highest_clr = 0;
    wrreq = 0;
    chk("clr_with_drop", b1.ovf_cnt, 0);
    aful_thres = 0;
    step(2);
    chk("afull_thr0", b0.almost_full, 1);
    aful_thres = 12;
    rst = 1;
    step();
    rst = 0;
    wrreq = 1;
    data = 'hA;
    step();
    wrreq = 0;
    chk("sa_q_a", b1.q, 'hA);
    chk("sa_nonempty", b1.empty, 0);
    wrreq = 1;
    data = 'hB;
    step();
    wrreq = 0;
    rdreq = 1;
    step();
    rdreq = 0;
    chk("sa_q_b", b1.q, 'hB);
    rdreq = 1;
    step();
    rdreq = 0;
    wrreq = 1;
    for (int i = 0; i < 8; i++) begin
      data = DW'(100 + i);
      step();
    end
    rdreq = 1;
    for (int i = 0; i < 40; i++) begin
      data = DW'(200 + i);
      step();
      if (i == 0) chk("wrap_first", b0.q, 100);
      if (i == 39) chk("wrap_last", b0.q, 231);
    end
    rdreq = 0;
    chk("wrap_usedw", b0.usedw, 8);
    for (int i = 0; i < 2; i++) begin
      data = DW'(300 + i);
      step();
    end
    data = 555;
    rst = 1;
    step();
    rst = 0;
    wrreq = 0;
    chk("mrst_usedw", b0.usedw, 0);
    chk("mrst_empty", b0.empty, 1);
    chk("mrst_q", b0.q, 0);
    chk("mrst_highest", b0.highest_dw, 0);
    wrreq = 1;
    data = 'h55;
    step();
    wrreq = 0;
    chk("mrst_sa_q", b1.q, 'h55);
    rdreq = 1;
    step();
    rdreq = 0;
    chk("mrst_rd_q", b0.q, 'h55);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
